riscv_fetch_unit: RTL

Instruction fetch stage of the RISC-V core. It holds the fetch PC and issues word reads to a synchronous instruction ROM whose images are built from the team's opcode-encoding package. Returned words are buffered in a 2-entry queue and handed to decode over a valid/ready handshake, tagged with their PC and an illegal-opcode flag. Branch/jump redirects from execute flush all in-flight and buffered work.

---
 rtl/riscv_fetch_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/riscv_fetch_unit.sv
// ---------------------------------------------------------------------------
// riscv_fetch_unit
//
// Instruction fetch stage of the RISC-V core. It holds the fetch PC, issues
// one word read per cycle to a synchronous instruction ROM, buffers returned
// words in a two-entry FIFO and hands them to decode over a valid/ready
// handshake. Each delivered word carries its PC and an illegal-opcode flag.
// A redirect from execute flushes the buffer, squashes the response that is
// still on its way back and restarts fetch at the (word-aligned) target.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous, active-high reset
//   imem_req       read strobe to the instruction ROM
//   imem_addr      ROM word address (fetch_pc[IMEM_AW+1:2])
//   imem_rdata     ROM data, valid the cycle after imem_req
//   redirect_valid one-cycle pulse: restart fetch at redirect_pc
//   redirect_pc    redirect target, low two bits ignored
//   if_valid       queue head holds an instruction
//   if_ready       decode accepts the head this cycle
//   if_instr       head instruction word
//   if_pc          head instruction address
//   if_illegal     head opcode is not one of the supported base opcodes
// ---------------------------------------------------------------------------
module riscv_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [31:0]        if_instr,
    output logic [31:0]        if_pc,
    output logic               if_illegal
);

    // Fetch-side state
    logic [31:0] fetch_pc;
    logic        inflight;
    logic        epoch;
    logic        req_epoch;
    logic [31:0] req_pc;

    // Two-entry FIFO between the ROM and decode
    logic [1:0]  count;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [31:0] q_instr [2];
    logic [31:0] q_pc    [2];
    logic        q_ill   [2];

    // Per-cycle control
    logic        pop;
    logic [2:0]  occ;
    logic        room;
    logic        capture;
    logic        rdata_illegal;

    // Only the nine base opcodes the core implements are legal; everything
    // else (SYSTEM, FENCE, compressed encodings, all-zeros...) gets flagged
    // so decode can raise the trap when the word reaches it.
    function automatic logic is_illegal(input logic [6:0] opcode);
        logic bad;
        bad = 1'b1;
        case (opcode)
            7'b0010011,
            7'b0110011,
            7'b0110111,
            7'b0010111,
            7'b1101111,
            7'b1100111,
            7'b1100011,
            7'b0000011,
            7'b0100011: bad = 1'b0;
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Handshake and issue decisions. occ counts buffered words plus the one
    // response that may still be coming back, so a new request is only sent
    // when its data is guaranteed a free slot after this cycle's pop. This
    // is what makes FIFO overflow impossible without any backpressure on the
    // ROM. A redirect suppresses issue for one cycle and also kills the
    // capture of the response arriving in that same cycle.
    always_comb begin
        if_valid      = (count != 2'd0);
        pop           = if_valid & if_ready;
        occ           = {1'b0, count} + {2'b00, inflight};
        room          = (occ - {2'b00, pop}) < 3'd2;
        imem_req      = ~rst & ~redirect_valid & room;
        capture       = inflight & (req_epoch == epoch) & ~redirect_valid;
        rdata_illegal = is_illegal(imem_rdata[6:0]);
    end

    assign imem_addr = fetch_pc[IMEM_AW+1:2];

    // Head outputs are forced to zero when the queue is empty so nothing
    // stale is visible to decode after a flush or reset.
    always_comb begin
        if_instr   = 32'h0000_0000;
        if_pc      = 32'h0000_0000;
        if_illegal = 1'b0;
        if (if_valid) begin
            if_instr   = q_instr[rd_ptr];
            if_pc      = q_pc[rd_ptr];
            if_illegal = q_ill[rd_ptr];
        end
    end

    // Fetch PC, in-flight tracking and epoch. Each request remembers the PC
    // and epoch it was issued under; toggling the epoch on a redirect makes
    // any response tagged with the old epoch unusable. The PC wraps modulo
    // 2^32 naturally through the 32-bit add.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            inflight  <= 1'b0;
            epoch     <= 1'b0;
            req_epoch <= 1'b0;
            req_pc    <= 32'h0000_0000;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
                epoch    <= ~epoch;
            end else if (imem_req) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            inflight <= imem_req;
            if (imem_req) begin
                req_pc    <= fetch_pc;
                req_epoch <= epoch;
            end
        end
    end

    // FIFO pointers and occupancy. A redirect empties the queue outright;
    // otherwise capture and pop may happen together and cancel out in the
    // count while both pointers advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (redirect_valid) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (capture) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({capture, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage. The illegal flag is decoded once on the way in so the
    // head outputs stay plain register reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_instr[0] <= 32'h0000_0000;
            q_instr[1] <= 32'h0000_0000;
            q_pc[0]    <= 32'h0000_0000;
            q_pc[1]    <= 32'h0000_0000;
            q_ill[0]   <= 1'b0;
            q_ill[1]   <= 1'b0;
        end else if (capture) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= req_pc;
            q_ill[wr_ptr]   <= rdata_illegal;
        end
    end

endmodule
